// File: rtl/sa_ctrl_axil_slave.sv
// AXI4-Lite control/status register file for the systolic-array DMA pipeline.
// Optional PERF busy-cycle counter at 0x1C when SA_CTRL_PERF_CNT_EN is defined.
module sa_ctrl_axil_slave #(
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] VERSION_ID         = 32'h5AC0_0001
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            o_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   o_read_base_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   o_write_base_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   o_num_trans_param,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   o_max_blk_param,
    input  logic                            i_busy,
    input  logic                            i_done,
    input  logic                            i_error,
    output logic                            o_irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = AW - 2;

    localparam logic [IW-1:0] A_CTRL = IW'(0);
    localparam logic [IW-1:0] A_STAT = IW'(1);
    localparam logic [IW-1:0] A_RDB  = IW'(2);
    localparam logic [IW-1:0] A_WRB  = IW'(3);
    localparam logic [IW-1:0] A_NUM  = IW'(4);
    localparam logic [IW-1:0] A_BLK  = IW'(5);
    localparam logic [IW-1:0] A_ID   = IW'(6);
`ifdef SA_CTRL_PERF_CNT_EN
    localparam logic [IW-1:0] A_PERF = IW'(7);
`endif

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE, W_ADDR, W_DATA, W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE, R_DATA
    } r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [IW-1:0] awidx_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic [1:0]    bresp_q;

    logic          commit;
    logic [IW-1:0] c_idx;
    logic [DW-1:0] c_data;
    logic [SW-1:0] c_strb;

    logic          w_err;
    logic          sel_ctrl;
    logic          sel_stat;
    logic          start_go;
    logic          start_ok;
    logic          w1c;

    logic [DW-1:0] rd_base, wr_base, num_trans, max_blk;
    logic          ie, done_st, err_st, rej_st;
    logic          done_prev, err_prev;
    logic          start_q, irq_q;

    logic [IW-1:0] ar_idx;
    logic [DW-1:0] rd_val;
    logic          rd_err;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [DW-1:0] bw(
        input logic [DW-1:0] old,
        input logic [DW-1:0] d,
        input logic [SW-1:0] s
    );
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Write channel state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) w_state <= W_IDLE;
        else                w_state <= w_next;
    end

    // Write next-state, handshakes, and selection of held vs live beat.
    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        commit        = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    w_next = W_ADDR;
                end else if (S_AXI_WVALID) begin
                    w_next = W_DATA;
                end
            end
            W_ADDR: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_DATA: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        c_idx  = (w_state == W_ADDR) ? awidx_q
                                     : S_AXI_AWADDR[AW-1:2];
        c_data = (w_state == W_DATA) ? wdata_q : S_AXI_WDATA;
        c_strb = (w_state == W_DATA) ? wstrb_q : S_AXI_WSTRB;
    end

    // Write target decode and error classification.
    always_comb begin
        w_err    = 1'b0;
        sel_ctrl = 1'b0;
        sel_stat = 1'b0;
        case (c_idx)
            A_CTRL:                     sel_ctrl = 1'b1;
            A_STAT:                     sel_stat = 1'b1;
            A_RDB, A_WRB, A_NUM, A_BLK: w_err    = i_busy;
            default:                    w_err    = 1'b1;
        endcase
        start_go = commit && sel_ctrl && c_strb[0] && c_data[0];
        start_ok = start_go && !i_busy;
        w1c      = commit && sel_stat && c_strb[0];
    end

    // Hold the first-arriving beat and the write response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awidx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= OKAY;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY)
                awidx_q <= S_AXI_AWADDR[AW-1:2];
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) bresp_q <= w_err ? SLVERR : OKAY;
        end
    end

    // Configuration words; locked while the pipeline is busy.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_base   <= '0;
            wr_base   <= '0;
            num_trans <= '0;
            max_blk   <= '0;
        end else if (commit && !i_busy) begin
            case (c_idx)
                A_RDB: rd_base   <= bw(rd_base, c_data, c_strb);
                A_WRB: wr_base   <= bw(wr_base, c_data, c_strb);
                A_NUM: num_trans <= bw(num_trans, c_data, c_strb);
                A_BLK: max_blk   <= bw(max_blk, c_data, c_strb);
                default: ;
            endcase
        end
    end

    // Control, sticky status and interrupt; edge sets beat clears.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ie        <= 1'b0;
            done_st   <= 1'b0;
            err_st    <= 1'b0;
            rej_st    <= 1'b0;
            done_prev <= 1'b0;
            err_prev  <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            done_prev <= i_done;
            err_prev  <= i_error;
            start_q   <= start_ok;
            irq_q     <= ie & (done_st | err_st);
            if (commit && sel_ctrl && c_strb[0])
                ie <= c_data[1];
            if (i_done && !done_prev)
                done_st <= 1'b1;
            else if ((w1c && c_data[1]) || start_ok)
                done_st <= 1'b0;
            if (i_error && !err_prev)
                err_st <= 1'b1;
            else if ((w1c && c_data[2]) || start_ok)
                err_st <= 1'b0;
            if (start_go && i_busy)
                rej_st <= 1'b1;
            else if (w1c && c_data[3])
                rej_st <= 1'b0;
        end
    end

`ifdef SA_CTRL_PERF_CNT_EN
    logic [DW-1:0] perf;

    // Busy-cycle counter, restarted by each start pulse, saturating.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)
            perf <= '0;
        else if (start_q)
            perf <= '0;
        else if (i_busy && (perf != '1))
            perf <= perf + 1'b1;
    end
`endif

    // Read channel state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= R_IDLE;
        else                r_state <= r_next;
    end

    // Read next-state and handshakes.
    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read data mux.
    always_comb begin
        ar_idx = S_AXI_ARADDR[AW-1:2];
        rd_val = '0;
        rd_err = 1'b0;
        case (ar_idx)
            A_CTRL: rd_val[1]   = ie;
            A_STAT: rd_val[3:0] = {rej_st, err_st, done_st, i_busy};
            A_RDB:  rd_val      = rd_base;
            A_WRB:  rd_val      = wr_base;
            A_NUM:  rd_val      = num_trans;
            A_BLK:  rd_val      = max_blk;
            A_ID:   rd_val      = VERSION_ID;
`ifdef SA_CTRL_PERF_CNT_EN
            A_PERF: rd_val      = perf;
`endif
            default: rd_err     = 1'b1;
        endcase
    end

    // Capture read data at the address handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rdata_q <= rd_val;
            rresp_q <= rd_err ? SLVERR : OKAY;
        end
    end

    assign S_AXI_BRESP       = bresp_q;
    assign S_AXI_RDATA       = rdata_q;
    assign S_AXI_RRESP       = rresp_q;
    assign o_start           = start_q;
    assign o_irq             = irq_q;
    assign o_read_base_addr  = rd_base;
    assign o_write_base_addr = wr_base;
    assign o_num_trans_param = num_trans;
    assign o_max_blk_param   = max_blk;

endmodule

// File: tb/tb_sa_ctrl_axil_slave.sv
// Self-checking bench for sa_ctrl_axil_slave against a register-level model.
// Random config writes/reads plus directed start, status, irq and reset cases.
module tb_sa_ctrl_axil_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic        o_start, o_irq;
    logic [31:0] o_rdb, o_wrb, o_num, o_blk;
    logic        i_busy, i_done, i_error;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    // Model state: config words and control/status bits.
    logic [31:0] m_cfg [4];
    logic        m_ie, m_done, m_err, m_rej;

    always #5 clk = ~clk;

    always @(negedge clk) if (o_start === 1'b1) start_cnt++;

    sa_ctrl_axil_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .o_start(o_start),
        .o_read_base_addr(o_rdb), .o_write_base_addr(o_wrb),
        .o_num_trans_param(o_num), .o_max_blk_param(o_blk),
        .i_busy(i_busy), .i_done(i_done), .i_error(i_error),
        .o_irq(o_irq)
    );

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cfg[i] = 32'h0;
        m_ie = 0; m_done = 0; m_err = 0; m_rej = 0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic busy,
                               output logic [1:0] resp);
        int w;
        w = int'(a) / 4;
        resp = 2'b00;
        if (w == 0) begin
            if (s[0]) begin
                m_ie = d[1];
                if (d[0]) begin
                    if (busy) m_rej = 1;
                    else begin m_done = 0; m_err = 0; end
                end
            end
        end else if (w == 1) begin
            if (s[0]) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
                if (d[3]) m_rej = 0;
            end
        end else if (w >= 2 && w <= 5) begin
            if (busy) resp = 2'b10;
            else m_cfg[w-2] = merge(m_cfg[w-2], d, s);
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [5:0] a, input logic busy,
                              output logic [31:0] d,
                              output logic [1:0] resp);
        int w;
        w = int'(a) / 4;
        d = 32'h0;
        resp = 2'b00;
        if (w == 0) d[1] = m_ie;
        else if (w == 1) d[3:0] = {m_rej, m_err, m_done, busy};
        else if (w >= 2 && w <= 5) d = m_cfg[w-2];
        else if (w == 6) d = 32'h5AC0_0001;
        else resp = 2'b10;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_dly,
                             input int w_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        awvalid = 0;
        wvalid = 0;
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL wr_handshake addr=%h got aw=%0d w=%0d need 1 1",
                     a, aw_done, w_done);
            resp = 2'b11;
            return;
        end
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL bvalid_latency addr=%h got %b need 1", a, bvalid);
        end
        resp = bresp;
        bready = 1;
        cyc = 0;
        while (bvalid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        araddr = a;
        arvalid = 1;
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL arready_idle got %b need 1", arready);
        end
        @(posedge clk); #1;
        arvalid = 0;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rvalid_latency addr=%h got %b need 1", a, rvalid);
        end
        d = rdata;
        resp = rresp;
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; rready = 0;
        i_busy = 0; i_done = 0; i_error = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        logic [1:0]  r, er;
        do_reset();
        checks++;
        if ({bvalid, rvalid, o_start, o_irq, bresp, rresp} !== 8'h0 ||
            rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got bv=%b rv=%b st=%b irq=%b rd=%h need 0",
                     bvalid, rvalid, o_start, o_irq, rdata);
        end
        checks++;
        if ({o_rdb, o_wrb, o_num, o_blk} !== 128'h0) begin
            errors++;
            $display("FAIL reset_cfg got %h %h %h %h need 0",
                     o_rdb, o_wrb, o_num, o_blk);
        end
        axi_read(6'h04, d, r);
        model_read(6'h04, i_busy, e, er);
        checks++;
        if (d !== e || r !== er) begin
            errors++;
            $display("FAIL reset_status got %h/%b need %h/%b", d, r, e, er);
        end
    endtask

    task automatic test_basic();
        logic [1:0]  r, er;
        logic [31:0] d, e;
        model_write(6'h08, 32'h1000_0000, 4'hF, 0, er);
        axi_write(6'h08, 32'h1000_0000, 4'hF, 0, 1, r);
        model_write(6'h0C, 32'h2000_0000, 4'hF, 0, er);
        axi_write(6'h0C, 32'h2000_0000, 4'hF, 0, 0, r);
        checks++;
        if (r !== er) begin
            errors++;
            $display("FAIL basic_bresp got %b need %b", r, er);
        end
        checks++;
        if (o_rdb !== m_cfg[0] || o_wrb !== m_cfg[1]) begin
            errors++;
            $display("FAIL basic_cfg_out got %h %h need %h %h",
                     o_rdb, o_wrb, m_cfg[0], m_cfg[1]);
        end
        for (int i = 0; i < 2; i++) begin
            axi_read(6'(8 + 4 * i), d, r);
            model_read(6'(8 + 4 * i), i_busy, e, er);
            checks++;
            if (d !== e || r !== er) begin
                errors++;
                $display("FAIL basic_readback%0d got %h/%b need %h/%b",
                         i, d, r, e, er);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  r, er;
        logic [31:0] d, e;
        model_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, er);
        axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
        model_write(6'h10, 32'h0000_0010, 4'b0001, 0, er);
        axi_write(6'h10, 32'h0000_0010, 4'b0001, 3, 0, r);
        axi_read(6'h10, d, r);
        model_read(6'h10, i_busy, e, er);
        checks++;
        if (d !== e || d !== 32'hFFFF_FF10) begin
            errors++;
            $display("FAIL strobe_w_first got %h need %h", d, e);
        end
    endtask

    task automatic test_random();
        logic [5:0]  a;
        logic [31:0] dv, d, e;
        logic [3:0]  s;
        logic [1:0]  r, er;
        logic        busy;
        for (int n = 0; n < 40; n++) begin
            busy = ($urandom_range(0, 3) == 0);
            i_busy = busy;
            a  = 6'($urandom_range(2, 7) * 4);
            dv = $urandom;
            s  = 4'($urandom_range(0, 15));
            model_write(a, dv, s, busy, er);
            axi_write(a, dv, s, $urandom_range(0, 3),
                      $urandom_range(0, 3), r);
            checks++;
            if (r !== er) begin
                errors++;
                $display("FAIL rand_bresp n=%0d addr=%h got %b need %b",
                         n, a, r, er);
            end
        end
        i_busy = 0;
        checks++;
        if (o_rdb !== m_cfg[0] || o_wrb !== m_cfg[1] ||
            o_num !== m_cfg[2] || o_blk !== m_cfg[3]) begin
            errors++;
            $display("FAIL rand_cfg_out got %h %h %h %h need %h %h %h %h",
                     o_rdb, o_wrb, o_num, o_blk,
                     m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]);
        end
        for (int n = 0; n < 12; n++) begin
            do a = 6'($urandom_range(0, 15) * 4);
            while (a == 6'h1C);
            axi_read(a, d, r);
            model_read(a, i_busy, e, er);
            checks++;
            if (d !== e || r !== er) begin
                errors++;
                $display("FAIL rand_read addr=%h got %h/%b need %h/%b",
                         a, d, r, e, er);
            end
        end
    endtask

    task automatic test_start_irq();
        logic [1:0]  r, er;
        logic [31:0] d, e;
        int          s0;
        i_busy = 0;
        s0 = start_cnt;
        model_write(6'h00, 32'h3, 4'hF, 0, er);
        axi_write(6'h00, 32'h3, 4'hF, 0, 0, r);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL start_pulse got %0d cycles need 1", start_cnt - s0);
        end
        i_done = 1;
        m_done = 1;
        @(posedge clk); #1;
        checks++;
        if (o_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early got %b need 0", o_irq);
        end
        @(posedge clk); #1;
        checks++;
        if (o_irq !== (m_ie & (m_done | m_err))) begin
            errors++;
            $display("FAIL irq_set got %b need 1", o_irq);
        end
        i_done = 0;
        axi_read(6'h04, d, r);
        model_read(6'h04, i_busy, e, er);
        checks++;
        if (d !== e || d !== 32'h2) begin
            errors++;
            $display("FAIL status_done got %h need %h", d, e);
        end
        model_write(6'h04, 32'h2, 4'hF, 0, er);
        axi_write(6'h04, 32'h2, 4'hF, 0, 0, r);
        @(posedge clk); #1;
        axi_read(6'h04, d, r);
        model_read(6'h04, i_busy, e, er);
        checks++;
        if (d !== e || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL status_w1c got %h irq=%b need %h irq=0",
                     d, o_irq, e);
        end
    endtask

    task automatic test_busy();
        logic [1:0]  r, er;
        logic [31:0] d, e, dv;
        int          s0;
        i_busy = 1;
        s0 = start_cnt;
        model_write(6'h00, 32'h1, 4'hF, 1, er);
        axi_write(6'h00, 32'h1, 4'hF, 0, 0, r);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (start_cnt !== s0 || r !== er) begin
            errors++;
            $display("FAIL busy_start got pulses=%0d bresp=%b need 0/%b",
                     start_cnt - s0, r, er);
        end
        axi_read(6'h04, d, r);
        model_read(6'h04, i_busy, e, er);
        checks++;
        if (d !== e || d[3] !== 1'b1) begin
            errors++;
            $display("FAIL busy_rej got %h need %h", d, e);
        end
        dv = $urandom;
        model_write(6'h14, dv, 4'hF, 1, er);
        axi_write(6'h14, dv, 4'hF, 1, 0, r);
        checks++;
        if (r !== 2'b10 || r !== er) begin
            errors++;
            $display("FAIL busy_cfg_bresp got %b need %b", r, er);
        end
        axi_read(6'h14, d, r);
        model_read(6'h14, i_busy, e, er);
        checks++;
        if (d !== e || o_blk !== e) begin
            errors++;
            $display("FAIL busy_cfg_kept got %h out=%h need %h", d, o_blk, e);
        end
        model_write(6'h04, 32'h8, 4'hF, 1, er);
        axi_write(6'h04, 32'h8, 4'hF, 0, 2, r);
        i_busy = 0;
    endtask

    task automatic test_id();
        logic [1:0]  r, er;
        logic [31:0] d, e;
        axi_read(6'h18, d, r);
        model_read(6'h18, i_busy, e, er);
        checks++;
        if (d !== e || r !== er) begin
            errors++;
            $display("FAIL id_read got %h/%b need %h/%b", d, r, e, er);
        end
        axi_read(6'h24, d, r);
        model_read(6'h24, i_busy, e, er);
        checks++;
        if (d !== e || r !== er) begin
            errors++;
            $display("FAIL unmapped_read got %h/%b need %h/%b", d, r, e, er);
        end
`ifndef SA_CTRL_PERF_CNT_EN
        axi_read(6'h1C, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL perf_absent got %h/%b need 0/10", d, r);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] d0, e;
        logic [1:0]  er;
        model_read(6'h08, i_busy, e, er);
        araddr = 6'h08;
        arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        d0 = rdata;
        checks++;
        if (d0 !== e) begin
            errors++;
            $display("FAIL stall_data got %h need %h", d0, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rvalid !== 1'b1 || rdata !== e) begin
                errors++;
                $display("FAIL stall_hold c=%0d got rv=%b %h need 1 %h",
                         i, rvalid, rdata, e);
            end
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic test_reset_mid();
        araddr = 6'h0C;
        arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        rstn = 0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_valid got rv=%b bv=%b need 0 0",
                     rvalid, bvalid);
        end
        checks++;
        if ({o_rdb, o_wrb, o_num, o_blk} !== 128'h0 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_cfg got %h %h %h %h need 0",
                     o_rdb, o_wrb, o_num, o_blk);
        end
        model_reset();
        @(posedge clk); #1;
        rstn = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_random();
        test_start_irq();
        test_busy();
        test_id();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_ctrl_axil_slave.md
Name: sa_ctrl_axil_slave

Overview:
AXI4-Lite slave register file that programs the systolic-array DMA pipeline and reports its status. It converts host register writes into the pipeline's start pulse and configuration words (read/write base address, transfer size, block count). It sits directly upstream of the pipeline, in the same S_AXI_ACLK domain. It captures the pipeline's busy/done/error levels as sticky status bits and drives a maskable interrupt.

Parameters:
C_S_AXI_ADDR_WIDTH, 6, byte-address width; decode uses bits [C_S_AXI_ADDR_WIDTH-1:2].
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
VERSION_ID, 32'h5AC0_0001, constant returned by the ID register.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
S_AXI_BRESP  out  2  00 = OKAY, 10 = SLVERR
S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
o_start  out  1  single-cycle start pulse to the pipeline
o_read_base_addr, o_write_base_addr, o_num_trans_param, o_max_blk_param  out  32 each  configuration words
i_busy, i_done, i_error  in  1 each  pipeline status levels
o_irq  out  1  level interrupt

Behaviour:
- Clock and reset: clock S_AXI_ACLK; reset S_AXI_ARESETN, asynchronous, active-low.
- Reset values:
  - All registers 0.
  - BVALID, RVALID, RDATA, BRESP, RRESP, o_start and o_irq are 0.
  - Write FSM resets to W_IDLE; read FSM resets to R_IDLE.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IE (R/W).
  - 0x04 STATUS: bit0 BUSY (live i_busy, RO); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C); bit3 START_REJ (sticky, W1C).
  - 0x08 RD_BASE, 0x0C WR_BASE, 0x10 NUM_TRANS, 0x14 MAX_BLK: R/W, WSTRB byte-granular.
  - 0x18 ID: RO, returns VERSION_ID.
  - Any other offset is unmapped.
- Write FSM states:
  - W_IDLE: AWREADY = 1, WREADY = 1.
  - W_ADDR (address held, waiting for data): WREADY = 1 only.
  - W_DATA (data held, waiting for address): AWREADY = 1 only.
  - W_RESP: BVALID = 1, held until BREADY.
- Write commit:
  - Occurs on the edge where the second of AW/W completes; AW and W in the same cycle is legal.
  - BVALID rises the next cycle.
  - W_RESP returns to W_IDLE on BREADY.
  - One write outstanding at a time.
- SLVERR on write: unmapped offset; writes to ID; writes to 0x08–0x14 while i_busy = 1. In all three cases the register is left unchanged.
- Read FSM:
  - R_IDLE has ARREADY = 1. RDATA/RRESP are registered at the AR handshake, and RVALID rises the next cycle.
  - R_DATA holds RDATA stable until RREADY, then returns to R_IDLE.
  - Unmapped offset: RDATA = 0, RRESP = SLVERR.
  - Reads have no side effects.
- Start:
  - CTRL write with WSTRB[0] = 1 and WDATA[0] = 1, while i_busy = 0: o_start is high for exactly one cycle, the cycle after commit. The same edge clears DONE and ERR.
  - Same write while i_busy = 1: no pulse; START_REJ is set; BRESP = OKAY.
  - IE is updated by the same write regardless of busy.
- Sticky status bits:
  - DONE sets on the rising edge of i_done (previous value registered). ERR sets on the rising edge of i_error.
  - Set wins over a simultaneous W1C.
  - The start-induced clear loses to a simultaneous rising edge.
- Interrupt: o_irq = IE & (DONE | ERR), registered, so one-cycle latency from the sticky bit.
- Config outputs: o_*_param / addr outputs mirror their registers continuously.
- Read and write FSMs operate independently; a read of a register in the cycle it is written returns the pre-commit value.
- Reset mid-transaction: both FSMs abort to idle, VALID outputs drop immediately, and any pending write is discarded.

Optional Feature:
SA_CTRL_PERF_CNT_EN:
- Defined: adds 0x1C PERF (RO), a 32-bit counter.
  - Cleared on o_start; increments each cycle i_busy = 1; saturates at 32'hFFFF_FFFF.
- Undefined: 0x1C is unmapped (read returns SLVERR, data 0) and no counter logic is built.

Test Plan:
- Write 0x08 = 0x1000_0000, then AW and W in the same cycle for 0x0C = 0x2000_0000 -> BVALID one cycle after handshake, BRESP = 00; o_read_base_addr = 0x1000_0000, o_write_base_addr = 0x2000_0000; readback matches.
- W precedes AW by 3 cycles, writing 0x10 with WSTRB = 4'b0001 and data 0x0000_0010 over old value 0xFFFF_FFFF -> register reads 0xFFFF_FF10.
- Write CTRL = 0x3 with i_busy = 0 -> o_start high for exactly 1 cycle. Then raise i_done -> STATUS reads 0x2, o_irq = 1 one cycle later. Write STATUS = 0x2 -> DONE = 0, o_irq = 0.
- With i_busy = 1: CTRL = 0x1 -> no o_start, STATUS bit3 = 1. Write 0x14 -> BRESP = 10, register unchanged.
- Read 0x18 -> 0x5AC0_0001 with RRESP = 00. Read 0x24 -> RDATA = 0, RRESP = 10.
- Hold RREADY = 0 for 5 cycles -> RDATA stable. Assert reset mid-read -> RVALID = 0 immediately; all config outputs = 0.
